// File: rtl/fft_spi_in.sv
// SPI mode-0 slave receiver: collects N words of MSB bits into one frame and
// publishes it on data_bus with a one-cycle frame_valid strobe.
module fft_spi_in #(
  parameter int N       = 32,
  parameter int MSB     = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               sclk,
  input  logic               mosi,
  input  logic               cs,
  output logic [N*MSB-1:0]   data_bus,
  output logic               frame_valid,
  output logic               frame_err
);

  localparam int WW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MSB);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t             r_state, w_state_nx;
  logic               r_sclk_s1, r_sclk_s2, r_sclk_h;
  logic               r_cs_s1, r_cs_s2, r_cs_h;
  logic               r_mosi_s1, r_mosi_s2, r_mosi_h;
  logic               r_rise, r_cs_rise, r_word_vld;
  logic [MSB-1:0]     r_shift;
  logic [BW-1:0]      r_bcnt;
  logic [WW-1:0]      r_wcnt, w_wcnt_nx, w_slot;
  logic [TW-1:0]      r_tcnt, w_tcnt_nx;
  logic [N*MSB-1:0]   r_stage;
  logic               w_sclk_rise, w_cs_rise, w_wr, w_tmo, w_publish;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_h & ~r_cs_s2;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_h;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_h <= 1'b0;
      r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_h   <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0; r_mosi_h <= 1'b0;
      r_rise    <= 1'b0;
      r_cs_rise <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk; r_sclk_s2 <= r_sclk_s1; r_sclk_h <= r_sclk_s2;
      r_cs_s1   <= cs;   r_cs_s2   <= r_cs_s1;   r_cs_h   <= r_cs_s2;
      r_mosi_s1 <= mosi; r_mosi_s2 <= r_mosi_s1; r_mosi_h <= r_mosi_s2;
      r_rise    <= w_sclk_rise;
      r_cs_rise <= w_cs_rise;
    end
  end

  // r_mosi_h lines up with r_rise: it holds the synced mosi from the detect cycle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (r_rise) r_shift <= {r_shift[MSB-2:0], r_mosi_h};
      if (w_tmo || r_cs_rise) begin
        r_bcnt <= '0;
      end else if (r_rise) begin
        if (r_bcnt == BW'(MSB-1)) begin
          r_bcnt     <= '0;
          r_word_vld <= 1'b1;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_wcnt_nx  = r_wcnt;
    w_tcnt_nx  = '0;
    w_slot     = '0;
    w_wr       = 1'b0;
    w_tmo      = 1'b0;
    w_publish  = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        w_publish = (r_state == DONE);
        w_wcnt_nx = '0;
        w_state_nx = IDLE;
        // A word landing during DONE opens the next frame in slot 0.
        if (r_word_vld) begin
          w_wr = 1'b1;
          if (N == 1) begin
            w_state_nx = DONE;
          end else begin
            w_wcnt_nx  = WW'(1);
            w_state_nx = RECV;
          end
        end
      end
      RECV: begin
        w_tcnt_nx = r_tcnt + 1'b1;
        if (r_word_vld) begin
          w_wr      = 1'b1;
          w_slot    = r_wcnt;
          w_tcnt_nx = '0;
          if (r_wcnt == WW'(N-1)) begin
            w_wcnt_nx  = '0;
            w_state_nx = DONE;
          end else begin
            w_wcnt_nx = r_wcnt + 1'b1;
          end
        end else if (r_tcnt == TW'(TIMEOUT-1)) begin
          w_tmo      = 1'b1;
          w_wcnt_nx  = '0;
          w_tcnt_nx  = '0;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wcnt      <= '0;
      r_tcnt      <= '0;
      r_stage     <= '0;
      data_bus    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_wcnt      <= w_wcnt_nx;
      r_tcnt      <= w_tcnt_nx;
      frame_valid <= w_publish;
      frame_err   <= w_tmo;
      if (w_publish) data_bus <= r_stage;
      for (int unsigned k = 0; k < N; k++) begin
        if (w_wr && (w_slot == WW'(k))) r_stage[k*MSB +: MSB] <= r_shift;
      end
    end
  end

endmodule
